// File: rtl/palette_encoder_if.sv
// Pixel stream and index RAM write bus of the palette encoder.
// The encoder side uses the slave modport, the pixel source/RAM side the master modport.
interface palette_encoder_if #(
  parameter int unsigned PACK   = 8,
  parameter int unsigned ADDR_W = 7
);
  logic                  in_valid;
  logic [31:0]           in_pixel;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [3*PACK-1:0]     mem_wdata;

  modport slave (
    input  in_valid, in_pixel,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_pixel,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/palette_encoder.sv
// Palette encoder: maps ARGB pixels to 3-bit sprite palette indices, packs PACK indices per
// word and writes the words into index RAM, one image per start request.
module palette_encoder #(
  parameter int unsigned NUM_PIXELS = 1024,
  parameter int unsigned PACK       = 8,
  parameter int unsigned ADDR_W     = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  palette_encoder_if.slave    bus,
  output logic                busy,
  output logic                done,
  output logic [15:0]         miss_count
);
  localparam int unsigned PIX_W  = $clog2(NUM_PIXELS + 1);
  localparam int unsigned SLOT_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int unsigned WORD_W = 3 * PACK;

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StFin} state_e;

  state_e              state_q;
  logic [PIX_W-1:0]    pix_cnt_q;
  logic [SLOT_W-1:0]   slot_cnt_q;
  logic [ADDR_W-1:0]   word_cnt_q;
  logic [WORD_W-1:0]   pack_q;
  logic                in_ready_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [WORD_W-1:0]   mem_wdata_q;
  logic                busy_q;
  logic                done_q;
  logic [15:0]         miss_q;

  logic [2:0]          pix_idx;
  logic                accept;
  logic                last_pix;
  logic                last_slot;
  logic [WORD_W-1:0]   pack_next;

  // Colour-to-index lookup; anything not transparent or an exact opaque match is unmapped (7).
  always_comb begin
    pix_idx = 3'd7;
    if (bus.in_pixel[31:24] == 8'h00) begin
      pix_idx = 3'd0;
    end else if (bus.in_pixel[31:24] == 8'hFF) begin
      case (bus.in_pixel[23:0])
        24'h000000: pix_idx = 3'd1;
        24'h00821A: pix_idx = 3'd2;
        24'h06A300: pix_idx = 3'd3;
        24'h38D979: pix_idx = 3'd4;
        24'h75FFD6: pix_idx = 3'd5;
        24'h52DEA1: pix_idx = 3'd6;
        default:    pix_idx = 3'd7;
      endcase
    end
  end

  assign accept    = bus.in_valid & in_ready_q;
  assign last_pix  = (pix_cnt_q == PIX_W'(NUM_PIXELS - 1));
  assign last_slot = (slot_cnt_q == SLOT_W'(PACK - 1));
  assign pack_next = pack_q | (WORD_W'(pix_idx) << (3 * slot_cnt_q));

  // Control FSM with registered handshake, RAM write and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pix_cnt_q   <= '0;
      slot_cnt_q  <= '0;
      word_cnt_q  <= '0;
      pack_q      <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      miss_q      <= '0;
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StRun;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            pix_cnt_q  <= '0;
            slot_cnt_q <= '0;
            word_cnt_q <= '0;
            pack_q     <= '0;
            miss_q     <= '0;
          end
        end
        StRun: begin
          if (accept) begin
            pix_cnt_q <= pix_cnt_q + 1'b1;
            if (pix_idx == 3'd7 && miss_q != 16'hFFFF) begin
              miss_q <= miss_q + 16'd1;
            end
            if (last_pix) begin
              // Final word goes out now; unfilled slots remain zero.
              mem_we_q    <= 1'b1;
              mem_addr_q  <= word_cnt_q;
              mem_wdata_q <= pack_next;
              pack_q      <= '0;
              slot_cnt_q  <= '0;
              in_ready_q  <= 1'b0;
              state_q     <= StFlush;
            end else if (last_slot) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= word_cnt_q;
              mem_wdata_q <= pack_next;
              word_cnt_q  <= word_cnt_q + 1'b1;
              pack_q      <= '0;
              slot_cnt_q  <= '0;
            end else begin
              pack_q     <= pack_next;
              slot_cnt_q <= slot_cnt_q + 1'b1;
            end
          end
        end
        StFlush: begin
          state_q <= StFin;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign miss_count    = miss_q;

endmodule

// File: tb/tb_palette_encoder.sv
// Bench for palette_encoder: table-driven images, randomized images against a stream model,
// mid-image reset and miss counter saturation on a second, large instance.
module tb_palette_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Small instance: 10 pixels, 2 words per image.
  logic        a_start, a_busy, a_done;
  logic [15:0] a_miss;
  palette_encoder_if #(.PACK(8), .ADDR_W(2)) a_if ();
  palette_encoder #(.NUM_PIXELS(10), .PACK(8), .ADDR_W(2)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .bus(a_if.slave),
    .busy(a_busy), .done(a_done), .miss_count(a_miss)
  );

  // Large instance for miss_count saturation.
  logic        c_start, c_busy, c_done;
  logic [15:0] c_miss;
  palette_encoder_if #(.PACK(8), .ADDR_W(14)) c_if ();
  palette_encoder #(.NUM_PIXELS(66000), .PACK(8), .ADDR_W(14)) dut_c (
    .clk(clk), .rst(rst), .start(c_start), .bus(c_if.slave),
    .busy(c_busy), .done(c_done), .miss_count(c_miss)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [1:0]  wq_addr[$];
  logic [23:0] wq_data[$];
  int          wq_cyc[$];
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          c_writes = 0;
  int          c_last_addr = -1;

  logic [23:0] pal [6] = '{24'h000000, 24'h00821A, 24'h06A300, 24'h38D979, 24'h75FFD6, 24'h52DEA1};

  typedef struct {
    logic [31:0] px [10];
    logic [23:0] w0;
    logic [23:0] w1;
    int          miss;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference index rule from the palette definition.
  function automatic logic [2:0] ref_idx(input logic [31:0] p);
    if (p[31:24] == 8'h00) return 3'd0;
    if (p[31:24] == 8'hFF) begin
      for (int k = 0; k < 6; k++) if (p[23:0] == pal[k]) return 3'(k + 1);
    end
    return 3'd7;
  endfunction

  // Bus monitor, sampled 1 time unit after each rising edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (a_if.mem_we) begin
      wq_addr.push_back(a_if.mem_addr);
      wq_data.push_back(a_if.mem_wdata);
      wq_cyc.push_back(cyc);
    end
    if (a_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (c_if.mem_we) begin
      c_writes++;
      c_last_addr = int'(c_if.mem_addr);
    end
  end

  task automatic run_a(input logic [31:0] px [10], input logic [23:0] e0, input logic [23:0] e1,
                       input int em, input bit gaps, input bit spam, input string nm);
    int idx = 0;
    int g = 0;
    int acc_cyc = -1;
    bit busy_ok = 1'b1;
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
    // start with a valid unmapped pixel in the same IDLE cycle: must not be taken
    @(negedge clk);
    a_start = 1'b1;
    a_if.in_valid = 1'b1;
    a_if.in_pixel = 32'h8000_0000;
    while (idx < 10 && g < 200) begin
      @(negedge clk);
      g++;
      a_start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      if (a_busy !== 1'b1) busy_ok = 1'b0;
      a_if.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      a_if.in_pixel = px[idx];
      if (a_if.in_valid && a_if.in_ready) begin
        idx++;
        acc_cyc = cyc;
      end
    end
    @(negedge clk);
    a_start = 1'b0;
    a_if.in_valid = 1'b0;
    g = 0;
    while (done_cnt == 0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    chk({nm, " accepted"}, 64'(idx), 64'd10);
    chk({nm, " busy_in_run"}, 64'(busy_ok), 64'd1);
    chk({nm, " write_count"}, 64'(wq_data.size()), 64'd2);
    if (wq_data.size() == 2) begin
      chk({nm, " addr0"}, 64'(wq_addr[0]), 64'd0);
      chk({nm, " data0"}, 64'(wq_data[0]), 64'(e0));
      chk({nm, " addr1"}, 64'(wq_addr[1]), 64'd1);
      chk({nm, " data1"}, 64'(wq_data[1]), 64'(e1));
      chk({nm, " final_write_cycle"}, 64'(wq_cyc[1]), 64'(acc_cyc + 1));
    end
    chk({nm, " done_cycle"}, 64'(done_cyc), 64'(acc_cyc + 2));
    chk({nm, " done_count"}, 64'(done_cnt), 64'd1);
    chk({nm, " miss_count"}, 64'(a_miss), 64'(em));
    chk({nm, " busy_after"}, 64'(a_busy), 64'd0);
    chk({nm, " hold_we"}, 64'(a_if.mem_we), 64'd0);
    chk({nm, " hold_addr"}, 64'(a_if.mem_addr), 64'd1);
    chk({nm, " hold_data"}, 64'(a_if.mem_wdata), 64'(e1));
  endtask

  task automatic chk_a_zero(input string nm);
    chk({nm, " in_ready"}, 64'(a_if.in_ready), 64'd0);
    chk({nm, " mem_we"}, 64'(a_if.mem_we), 64'd0);
    chk({nm, " mem_addr"}, 64'(a_if.mem_addr), 64'd0);
    chk({nm, " mem_wdata"}, 64'(a_if.mem_wdata), 64'd0);
    chk({nm, " busy"}, 64'(a_busy), 64'd0);
    chk({nm, " done"}, 64'(a_done), 64'd0);
    chk({nm, " miss_count"}, 64'(a_miss), 64'd0);
  endtask

  initial begin
    logic [31:0] px [10];
    logic [47:0] stream;
    int em;
    int g;

    tbl[0].px = '{default: 32'hFF06_A300};
    tbl[0].w0 = 24'h6DB6DB; tbl[0].w1 = 24'h00001B; tbl[0].miss = 0;
    tbl[1].px = '{32'h00AB_CDEF, 32'hFF00_0000, 32'hFF00_821A, 32'hFF06_A300, 32'hFF38_D979,
                  32'hFF75_FFD6, 32'hFF52_DEA1, 32'hFF12_3456, 32'hFF00_0000, 32'h0000_0000};
    tbl[1].w0 = 24'hFAC688; tbl[1].w1 = 24'h000001; tbl[1].miss = 1;
    tbl[2].px = '{32'h00FF_FFFF, 32'h8000_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000,
                  32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF52_DEA1, 32'hFF75_FFD6};
    tbl[2].w0 = 24'h249278; tbl[2].w1 = 24'h00002E; tbl[2].miss = 1;
    tbl[3].px = '{default: 32'hFE00_0000};
    tbl[3].w0 = 24'hFFFFFF; tbl[3].w1 = 24'h00003F; tbl[3].miss = 10;

    a_start = 1'b0; a_if.in_valid = 1'b0; a_if.in_pixel = '0;
    c_start = 1'b0; c_if.in_valid = 1'b0; c_if.in_pixel = '0;
    repeat (2) @(negedge clk);
    chk_a_zero("reset");
    rst = 1'b0;

    for (int r = 0; r < 4; r++) begin
      run_a(tbl[r].px, tbl[r].w0, tbl[r].w1, tbl[r].miss, 1'b0, 1'b0, $sformatf("tbl%0d", r));
    end
    // Random valid gaps and start pulses while running must not change the result.
    run_a(tbl[0].px, tbl[0].w0, tbl[0].w1, tbl[0].miss, 1'b1, 1'b1, "gaps");

    for (int n = 0; n < 6; n++) begin
      stream = '0;
      em = 0;
      for (int i = 0; i < 10; i++) begin
        case ($urandom_range(0, 3))
          0:       px[i] = {8'h00, 24'($urandom)};
          1, 2:    px[i] = {8'hFF, pal[$urandom_range(0, 5)]};
          default: px[i] = $urandom;
        endcase
        stream[3*i +: 3] = ref_idx(px[i]);
        if (ref_idx(px[i]) == 3'd7) em++;
      end
      run_a(px, stream[23:0], stream[47:24], em, 1'b1, n[0], $sformatf("rand%0d", n));
    end

    // Reset in the middle of an image.
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_if.in_valid = 1'b1;
    a_if.in_pixel = 32'h8000_0000;
    repeat (4) @(negedge clk);
    chk("midrst pre_busy", 64'(a_busy), 64'd1);
    chk("midrst pre_miss", 64'(a_miss), 64'd4);
    #2 rst = 1'b1;
    #1 chk_a_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    a_if.in_valid = 1'b0;
    run_a(tbl[1].px, tbl[1].w0, tbl[1].w1, tbl[1].miss, 1'b0, 1'b0, "after_rst");

    // Saturation: 66000 unmapped pixels.
    @(negedge clk);
    c_start = 1'b1;
    c_if.in_valid = 1'b1;
    c_if.in_pixel = 32'h0123_4567;
    @(negedge clk);
    c_start = 1'b0;
    g = 0;
    while (c_done !== 1'b1 && g < 70000) begin
      @(negedge clk);
      g++;
    end
    chk("sat done_seen", 64'(c_done), 64'd1);
    chk("sat miss_count", 64'(c_miss), 64'hFFFF);
    chk("sat write_count", 64'(c_writes), 64'd8250);
    chk("sat last_addr", 64'(c_last_addr), 64'd8249);
    c_if.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sat miss_hold", 64'(c_miss), 64'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
